// File: rtl/display_scan_ctrl.sv
// Multiplexed scan controller for a common-anode 7-segment display with dead-time between digits.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module display_scan_ctrl #(
  parameter int NDIG        = 4,
  parameter int DIG_CYCLES  = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              en,
  input  logic              load,
  input  logic [NDIG*4-1:0] value,
  input  logic [NDIG-1:0]   dp,
  output logic [NDIG-1:0]   an_n,
  output logic [6:0]        seg_n,
  output logic              dp_n,
  output logic              frame_done,
  output logic              upd_ack
);

  localparam int CMAX = (DIG_CYCLES > DEAD_CYCLES) ? DIG_CYCLES : DEAD_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic ST_DEAD = 1'b0;
  localparam logic ST_SHOW = 1'b1;

  logic              state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              frame_end;
  logic [NDIG*4-1:0] act_q, act_d, pend_q, pend_d;
  logic [NDIG-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic              pflag_q, pflag_d;
  logic              ack_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dpo_q, dpo_d;
  logic              fd_q;
  logic              ack_q;

  function automatic logic [6:0] decode(input logic [3:0] h);
    case (h)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    frame_end = 1'b0;
    if (!en) begin
      state_d = ST_DEAD;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (state_q == ST_DEAD) begin
      if (cnt_q == CW'(DEAD_CYCLES - 1)) begin
        state_d = ST_SHOW;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      if (cnt_q == CW'(DIG_CYCLES - 1)) begin
        state_d = ST_DEAD;
        cnt_d   = '0;
        if (idx_q == IW'(NDIG - 1)) begin
          idx_d     = '0;
          frame_end = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // A load coinciding with a commit point bypasses the pending registers.
  always_comb begin
    act_d     = act_q;
    act_dp_d  = act_dp_q;
    pend_d    = pend_q;
    pend_dp_d = pend_dp_q;
    pflag_d   = pflag_q;
    ack_d     = 1'b0;
    if (frame_end || !en) begin
      if (load) begin
        act_d    = value;
        act_dp_d = dp;
        pflag_d  = 1'b0;
        ack_d    = 1'b1;
      end else if (pflag_q) begin
        act_d    = pend_q;
        act_dp_d = pend_dp_q;
        pflag_d  = 1'b0;
        ack_d    = 1'b1;
      end
    end else if (load) begin
      pend_d    = value;
      pend_dp_d = dp;
      pflag_d   = 1'b1;
    end
  end

  // Outputs are computed from next state so the registered pins line up with state_q.
  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dpo_d = 1'b1;
    if (state_d == ST_SHOW) begin
      an_d[idx_d] = 1'b0;
      seg_d       = decode(act_d[{idx_d, 2'b00} +: 4]);
      dpo_d       = ~act_dp_d[idx_d];
`ifdef LEADING_ZERO_BLANK_EN
      if ((idx_d != '0) && ((act_d >> {idx_d, 2'b00}) == '0)) begin
        seg_d = 7'h7F;
      end
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_DEAD;
      idx_q     <= '0;
      cnt_q     <= '0;
      act_q     <= '0;
      act_dp_q  <= '0;
      pend_q    <= '0;
      pend_dp_q <= '0;
      pflag_q   <= 1'b0;
      an_q      <= '1;
      seg_q     <= 7'h7F;
      dpo_q     <= 1'b1;
      fd_q      <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      act_q     <= act_d;
      act_dp_q  <= act_dp_d;
      pend_q    <= pend_d;
      pend_dp_q <= pend_dp_d;
      pflag_q   <= pflag_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dpo_q     <= dpo_d;
      fd_q      <= frame_end;
      ack_q     <= ack_d;
    end
  end

  assign an_n       = an_q;
  assign seg_n      = seg_q;
  assign dp_n       = dpo_q;
  assign frame_done = fd_q;
  assign upd_ack    = ack_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench: a time-based reference model predicts every output cycle; a monitor compares.
module tb_display_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int DIG   = 4;
  localparam int DEAD  = 2;
  localparam int SLOT  = DIG + DEAD;
  localparam int FRAME = NDIG * SLOT;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n, frame_done, upd_ack;

  display_scan_ctrl #(.NDIG(NDIG), .DIG_CYCLES(DIG), .DEAD_CYCLES(DEAD)) dut (
    .clock(clock), .reset_n(reset_n), .en(en), .load(load), .value(value), .dp(dp),
    .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n), .frame_done(frame_done), .upd_ack(upd_ack)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dpn;
    logic       fd;
    logic       ua;
  } exp_t;

  localparam logic [6:0] SEGTAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          m_t = 0;
  logic [15:0] m_act = '0, m_pend = '0;
  logic [3:0]  m_act_dp = '0, m_pend_dp = '0;
  bit          m_pflag = 0;
  bit          done = 0;

  task automatic note_fail(input string name, input logic [12:0] got, input logic [12:0] want);
    miscompares++;
    if (miscompares <= 30)
      $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
  endtask

  // Reference model: scan position is elapsed enabled cycles modulo the frame length.
  initial begin
    exp_t e;
    bit fe;
    int f, s, p;
    forever begin
      @(posedge clock);
      e = '{an: 4'hF, seg: 7'h7F, dpn: 1'b1, fd: 1'b0, ua: 1'b0};
      if (!reset_n) begin
        m_t = 0; m_act = '0; m_act_dp = '0; m_pend = '0; m_pend_dp = '0; m_pflag = 0;
      end else begin
        fe = 0;
        if (!en) m_t = 0;
        else begin
          m_t++;
          fe = (m_t % FRAME) == 0;
        end
        if (fe || !en) begin
          if (load) begin
            m_act = value; m_act_dp = dp; m_pflag = 0; e.ua = 1'b1;
          end else if (m_pflag) begin
            m_act = m_pend; m_act_dp = m_pend_dp; m_pflag = 0; e.ua = 1'b1;
          end
        end else if (load) begin
          m_pend = value; m_pend_dp = dp; m_pflag = 1;
        end
        e.fd = fe;
        f = m_t % FRAME;
        s = f / SLOT;
        p = f % SLOT;
        if (p >= DEAD) begin
          e.an     = 4'hF & ~(4'h1 << s);
          e.seg    = SEGTAB[(m_act >> (4 * s)) & 16'hF];
          e.dpn    = ~m_act_dp[s];
`ifdef LEADING_ZERO_BLANK_EN
          if (s > 0 && (m_act >> (4 * s)) == 0) e.seg = 7'h7F;
`endif
        end
      end
      sb_q.push_back(e);
    end
  end

  // Monitor: compares the DUT's presented outputs against the oldest prediction.
  initial begin
    exp_t e, g;
    forever begin
      @(negedge clock);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        g = '{an: an_n, seg: seg_n, dpn: dp_n, fd: frame_done, ua: upd_ack};
        vectors++;
        if (g !== e) note_fail("outputs{an,seg,dp,fd,ack}", g, e);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load = 1'b1; value = v; dp = d;
    cyc(1);
    load = 1'b0;
  endtask

  // Waits (bounded) until the next edge will be a frame end or a lit digit.
  task automatic wait_phase(input bit want_fe, input string name);
    int k;
    k = 0;
    while (k < 200 && !(want_fe ? (((m_t + 1) % FRAME) == 0)
                                : (((m_t % SLOT) >= DEAD) && ((m_t % FRAME) / SLOT == 2)))) begin
      cyc(1);
      k++;
    end
    if (k >= 200) note_fail(name, 13'h0, 13'h1);
  endtask

  initial begin
    cyc(3);
    reset_n = 1'b1;
    en = 1'b1;
    cyc(60);
    do_load(16'h12AF, 4'b0100);
    cyc(60);
    do_load(16'h1111, 4'b0000);
    cyc(3);
    do_load(16'h2222, 4'b0000);
    cyc(50);
    wait_phase(1'b1, "wait_frame_end");
    do_load(16'hBEEF, 4'b1001);
    cyc(40);
    wait_phase(1'b0, "wait_digit2");
    en = 1'b0;
    do_load(16'h0005, 4'b0000);
    cyc(9);
    en = 1'b1;
    cyc(40);
    do_load(16'h0C30, 4'b0010);
    wait_phase(1'b0, "wait_digit2_rst");
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({an_n, seg_n, dp_n} !== {4'hF, 7'h7F, 1'b1})
      note_fail("async_reset_blank", {1'b0, an_n, seg_n, dp_n}, {1'b0, 4'hF, 7'h7F, 1'b1});
    cyc(3);
    reset_n = 1'b1;
    cyc(60);
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 79) == 0) en = ~en;
      else if (!en && $urandom_range(0, 5) == 0) en = 1'b1;
      load = ($urandom_range(0, 17) == 0);
      value = $urandom;
      if ($urandom_range(0, 2) == 0) value = value & (16'hFFFF >> (4 * $urandom_range(1, 4)));
      dp = $urandom;
      cyc(1);
    end
    load = 1'b0;
    en = 1'b1;
    cyc(3);
    done = 1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: got no end of stimulus, want completion");
      $fatal(1, "timeout");
    end
  end

endmodule
